// File: rtl/db_hash_table_if.sv
// Command/response bundle for the set-associative key/value table.
interface db_hash_table_if #(
    parameter int unsigned KEY_SIZE  = 96,
    parameter int unsigned VAL_SIZE  = 32,
    parameter int unsigned HASH_SIZE = 32,
    parameter int unsigned IDX_BITS  = 8,
    parameter int unsigned WAYS      = 2
);
    localparam int unsigned OCC_W = IDX_BITS + $clog2(WAYS) + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           in_flag;
    logic [HASH_SIZE-1:0] in_hash;
    logic [KEY_SIZE-1:0]  in_key;
    logic [VAL_SIZE-1:0]  in_value;
    logic                 out_valid;
    logic [3:0]           out_flag;
    logic [VAL_SIZE-1:0]  out_value;
    logic [OCC_W-1:0]     occupancy;

    modport master (
        output in_valid, in_flag, in_hash, in_key, in_value,
        input  in_ready, out_valid, out_flag, out_value, occupancy
    );

    modport slave (
        input  in_valid, in_flag, in_hash, in_key, in_value,
        output in_ready, out_valid, out_flag, out_value, occupancy
    );
endinterface

// File: rtl/db_hash_table.sv
// N-way set-associative key/value table with power-up clear sweep,
// lowest-way replacement and optional round-robin eviction.
module db_hash_table #(
    parameter int unsigned KEY_SIZE  = 96,
    parameter int unsigned VAL_SIZE  = 32,
    parameter int unsigned HASH_SIZE = 32,
    parameter int unsigned IDX_BITS  = 8,
    parameter int unsigned WAYS      = 2,
    parameter bit          EVICT_EN  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    db_hash_table_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << IDX_BITS;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned OCC_W = IDX_BITS + $clog2(WAYS) + 1;
    localparam int unsigned ENT_W = 1 + KEY_SIZE + VAL_SIZE;

    localparam logic [3:0] OP_LOOKUP   = 4'd1;
    localparam logic [3:0] OP_INSERT   = 4'd2;
    localparam logic [3:0] OP_DELETE   = 4'd3;
    localparam logic [3:0] ST_HIT      = 4'd1;
    localparam logic [3:0] ST_MISS     = 4'd2;
    localparam logic [3:0] ST_INSERTED = 4'd3;
    localparam logic [3:0] ST_UPDATED  = 4'd4;
    localparam logic [3:0] ST_EVICTED  = 4'd5;
    localparam logic [3:0] ST_FULL     = 4'd6;
    localparam logic [3:0] ST_DELETED  = 4'd7;
    localparam logic [3:0] ST_ERR      = 4'd15;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_CMP, S_RESP} state_e;

    state_e                state_q, state_d;
    logic [IDX_BITS-1:0]   sweep_q, sweep_d;
    logic [3:0]            op_q, op_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic [KEY_SIZE-1:0]   key_q, key_d;
    logic [VAL_SIZE-1:0]   val_q, val_d;
    logic                  hit_q, hit_d;
    logic                  full_q, full_d;
    logic [WAY_W-1:0]      hit_way_q, hit_way_d;
    logic [WAY_W-1:0]      free_way_q, free_way_d;
    logic [WAY_W-1:0]      victim_q, victim_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [3:0]            out_flag_q, out_flag_d;
    logic [VAL_SIZE-1:0]   out_value_q, out_value_d;

    logic [WAYS-1:0]       we_c;
    logic [IDX_BITS-1:0]   wr_idx_c;
    logic [ENT_W-1:0]      wr_data_c;
    logic [WAYS-1:0]       valid_c;
    logic [WAYS-1:0]       match_c;
    logic [VAL_SIZE-1:0]   rd_val_c [WAYS];
    logic                  hit_c;
    logic                  full_c;
    logic [WAY_W-1:0]      hit_way_c;
    logic [WAY_W-1:0]      free_way_c;

    // Upper hash bits do not take part in indexing.
    logic unused_hash;
    assign unused_hash = ^bus.in_hash[HASH_SIZE-1:IDX_BITS];

    // One synchronous RAM per way holding {valid, key, value}.
    for (genvar gw = 0; gw < int'(WAYS); gw++) begin : g_way
        logic [ENT_W-1:0] mem [DEPTH];
        logic [ENT_W-1:0] rd_q;

        // Write port (sweep clear or command commit) and registered read.
        always_ff @(posedge clk) begin
            if (we_c[gw]) begin
                mem[wr_idx_c] <= wr_data_c;
            end
            if (state_q == S_RD) begin
                rd_q <= mem[idx_q];
            end
        end

        assign valid_c[gw]  = rd_q[ENT_W-1];
        assign rd_val_c[gw] = rd_q[VAL_SIZE-1:0];
        assign match_c[gw]  = rd_q[ENT_W-1] && (rd_q[ENT_W-2:VAL_SIZE] == key_q);
    end

    // Priority-encode lowest matching way and lowest free way.
    always_comb begin
        hit_c      = 1'b0;
        full_c     = 1'b1;
        hit_way_c  = '0;
        free_way_c = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (match_c[w]) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
            if (!valid_c[w]) begin
                full_c     = 1'b0;
                free_way_c = WAY_W'(w);
            end
        end
    end

    // Next-state, response and RAM write control.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        op_d        = op_q;
        idx_d       = idx_q;
        key_d       = key_q;
        val_d       = val_q;
        hit_d       = hit_q;
        full_d      = full_q;
        hit_way_d   = hit_way_q;
        free_way_d  = free_way_q;
        victim_d    = victim_q;
        occ_d       = occ_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        out_flag_d  = out_flag_q;
        out_value_d = out_value_q;
        we_c        = '0;
        wr_idx_c    = sweep_q;
        wr_data_c   = '0;

        case (state_q)
            S_INIT: begin
                we_c    = '1;
                sweep_d = sweep_q + IDX_BITS'(1);
                if (sweep_q == IDX_BITS'(DEPTH - 1)) begin
                    state_d    = S_IDLE;
                    in_ready_d = 1'b1;
                end
            end
            S_IDLE: begin
                in_ready_d = 1'b1;
                if (bus.in_valid && in_ready_q) begin
                    op_d       = bus.in_flag;
                    idx_d      = bus.in_hash[IDX_BITS-1:0];
                    key_d      = bus.in_key;
                    val_d      = bus.in_value;
                    in_ready_d = 1'b0;
                    state_d    = S_RD;
                end
            end
            S_RD: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                hit_d       = hit_c;
                full_d      = full_c;
                hit_way_d   = hit_way_c;
                free_way_d  = free_way_c;
                out_valid_d = 1'b1;
                out_value_d = '0;
                case (op_q)
                    OP_LOOKUP: begin
                        out_flag_d = hit_c ? ST_HIT : ST_MISS;
                        if (hit_c) out_value_d = rd_val_c[hit_way_c];
                    end
                    OP_INSERT: begin
                        if (hit_c) begin
                            out_flag_d  = ST_UPDATED;
                            out_value_d = rd_val_c[hit_way_c];
                        end else if (!full_c) begin
                            out_flag_d = ST_INSERTED;
                        end else if (EVICT_EN) begin
                            out_flag_d  = ST_EVICTED;
                            out_value_d = rd_val_c[victim_q];
                        end else begin
                            out_flag_d = ST_FULL;
                        end
                    end
                    OP_DELETE: begin
                        out_flag_d = hit_c ? ST_DELETED : ST_MISS;
                        if (hit_c) out_value_d = rd_val_c[hit_way_c];
                    end
                    default: out_flag_d = ST_ERR;
                endcase
                state_d = S_RESP;
            end
            S_RESP: begin
                wr_idx_c  = idx_q;
                wr_data_c = {1'b1, key_q, val_q};
                if (op_q == OP_INSERT) begin
                    if (hit_q) begin
                        we_c[hit_way_q] = 1'b1;
                    end else if (!full_q) begin
                        we_c[free_way_q] = 1'b1;
                        if (occ_q != OCC_W'(DEPTH * WAYS)) occ_d = occ_q + OCC_W'(1);
                    end else if (EVICT_EN) begin
                        we_c[victim_q] = 1'b1;
                        victim_d = (victim_q == WAY_W'(WAYS - 1)) ? '0 : victim_q + WAY_W'(1);
                    end
                end else if (op_q == OP_DELETE && hit_q) begin
                    wr_data_c       = {1'b0, key_q, val_q};
                    we_c[hit_way_q] = 1'b1;
                    if (occ_q != '0) occ_d = occ_q - OCC_W'(1);
                end
                in_ready_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_INIT;
            sweep_q     <= '0;
            op_q        <= '0;
            idx_q       <= '0;
            key_q       <= '0;
            val_q       <= '0;
            hit_q       <= 1'b0;
            full_q      <= 1'b0;
            hit_way_q   <= '0;
            free_way_q  <= '0;
            victim_q    <= '0;
            occ_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_flag_q  <= '0;
            out_value_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            key_q       <= key_d;
            val_q       <= val_d;
            hit_q       <= hit_d;
            full_q      <= full_d;
            hit_way_q   <= hit_way_d;
            free_way_q  <= free_way_d;
            victim_q    <= victim_d;
            occ_q       <= occ_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_flag_q  <= out_flag_d;
            out_value_q <= out_value_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_flag  = out_flag_q;
    assign bus.out_value = out_value_q;
    assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_db_hash_table.sv
// Scoreboard bench: two tables (evicting and non-evicting) fed the same commands.
module tb_db_hash_table;
    localparam int unsigned IDX_BITS = 4;
    localparam int unsigned WAYS     = 2;
    localparam int          DEPTH    = 16;

    localparam logic [3:0] LK = 4'd1, INS = 4'd2, DEL = 4'd3;
    localparam logic [3:0] HIT = 4'd1, MISS = 4'd2, INSD = 4'd3, UPD = 4'd4;
    localparam logic [3:0] EVT = 4'd5, FULL = 4'd6, DELD = 4'd7, ERR = 4'd15;

    localparam logic [95:0] KA = 96'h0A0A_0A0A_1111_2222_3333_0001;
    localparam logic [95:0] KP = 96'hC0A8_0001_C0A8_0002_0050_0006;
    localparam logic [95:0] KQ = 96'hC0A8_0001_C0A8_0002_0051_0006;
    localparam logic [95:0] KR = 96'hC0A8_0001_C0A8_0002_0052_0006;
    localparam logic [95:0] KS = 96'hC0A8_0001_C0A8_0002_0053_0011;
    localparam logic [95:0] KU = 96'hC0A8_0001_C0A8_0002_0054_0011;
    localparam logic [95:0] KT = 96'h1234_5678_9ABC_DEF0_0000_0007;

    typedef struct {
        logic [3:0]  flag;
        logic [31:0] value;
        int          cyc;
        int          occ;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb_ev[$];
    exp_t sb_fu[$];
    bit   pend[2];
    int   pend_occ[2];

    db_hash_table_if #(.KEY_SIZE(96), .VAL_SIZE(32), .HASH_SIZE(32),
                       .IDX_BITS(IDX_BITS), .WAYS(WAYS)) bus_ev ();
    db_hash_table_if #(.KEY_SIZE(96), .VAL_SIZE(32), .HASH_SIZE(32),
                       .IDX_BITS(IDX_BITS), .WAYS(WAYS)) bus_fu ();

    assign bus_fu.in_valid = bus_ev.in_valid;
    assign bus_fu.in_flag  = bus_ev.in_flag;
    assign bus_fu.in_hash  = bus_ev.in_hash;
    assign bus_fu.in_key   = bus_ev.in_key;
    assign bus_fu.in_value = bus_ev.in_value;

    db_hash_table #(.KEY_SIZE(96), .VAL_SIZE(32), .HASH_SIZE(32), .IDX_BITS(IDX_BITS),
                    .WAYS(WAYS), .EVICT_EN(1'b1)) u_ev (.clk(clk), .rst(rst), .bus(bus_ev));
    db_hash_table #(.KEY_SIZE(96), .VAL_SIZE(32), .HASH_SIZE(32), .IDX_BITS(IDX_BITS),
                    .WAYS(WAYS), .EVICT_EN(1'b0)) u_fu (.clk(clk), .rst(rst), .bus(bus_fu));

    always #5 clk = ~clk;

    // Cycle index since reset release; cycle k ends with the k-th rising edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic bit sb_empty(int d);
        return (d == 0) ? (sb_ev.size() == 0) : (sb_fu.size() == 0);
    endfunction

    function automatic exp_t sb_pop(int d);
        return (d == 0) ? sb_ev.pop_front() : sb_fu.pop_front();
    endfunction

    function automatic int sb_front_cyc(int d);
        return (d == 0) ? sb_ev[0].cyc : sb_fu[0].cyc;
    endfunction

    // Per-DUT response monitor: matches each out_valid against the scoreboard.
    task automatic mon_dut(input int d, input logic ov, input logic [3:0] fl,
                           input logic [31:0] vl, input logic rdy, input logic [5:0] oc);
        exp_t  e;
        string tag;
        tag = (d == 0) ? "ev" : "fu";
        if (pend[d]) begin
            pend[d] = 1'b0;
            chk($sformatf("%s.occupancy", tag), 32'(oc), 32'(pend_occ[d]));
            chk($sformatf("%s.ready_after_resp", tag), 32'(rdy), 32'd1);
        end
        if (!sb_empty(d) && sb_front_cyc(d) < cyc) begin
            e = sb_pop(d);
            chk($sformatf("%s.%s.no_response_cycle", tag, e.name), 32'(cyc), 32'(e.cyc));
        end
        if (ov === 1'b1) begin
            if (sb_empty(d)) begin
                chk($sformatf("%s.unexpected_out_valid", tag), 32'(ov), 32'd0);
            end else begin
                e = sb_pop(d);
                chk($sformatf("%s.%s.cycle", tag, e.name), 32'(cyc), 32'(e.cyc));
                chk($sformatf("%s.%s.flag", tag, e.name), 32'(fl), 32'(e.flag));
                chk($sformatf("%s.%s.value", tag, e.name), vl, e.value);
                chk($sformatf("%s.%s.busy", tag, e.name), 32'(rdy), 32'd0);
                pend[d]     = 1'b1;
                pend_occ[d] = e.occ;
            end
        end
    endtask

    // Single checking process, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            if (cyc == 0) begin
                chk("ev.reset_occupancy", 32'(bus_ev.occupancy), 32'd0);
                chk("ev.reset_out_flag", 32'(bus_ev.out_flag), 32'd0);
                chk("ev.reset_out_value", bus_ev.out_value, 32'd0);
                chk("fu.reset_occupancy", 32'(bus_fu.occupancy), 32'd0);
            end
            if (cyc <= DEPTH) begin
                chk($sformatf("ev.sweep_ready_c%0d", cyc), 32'(bus_ev.in_ready), 32'(cyc == DEPTH));
                chk($sformatf("fu.sweep_ready_c%0d", cyc), 32'(bus_fu.in_ready), 32'(cyc == DEPTH));
            end
            mon_dut(0, bus_ev.out_valid, bus_ev.out_flag, bus_ev.out_value,
                    bus_ev.in_ready, bus_ev.occupancy);
            mon_dut(1, bus_fu.out_valid, bus_fu.out_flag, bus_fu.out_value,
                    bus_fu.in_ready, bus_fu.occupancy);
        end else begin
            pend[0] = 1'b0;
            pend[1] = 1'b0;
        end
    end

    // Drive one command, wait for accept, and queue the expected responses.
    task automatic issue(input string name, input logic [3:0] op, input logic [31:0] hash,
                         input logic [95:0] key, input logic [31:0] val, input bit want,
                         input logic [3:0] fe, input logic [31:0] ve, input int oe,
                         input logic [3:0] ff, input logic [31:0] vf, input int of_);
        int n;
        @(negedge clk);
        bus_ev.in_flag  = op;
        bus_ev.in_hash  = hash;
        bus_ev.in_key   = key;
        bus_ev.in_value = val;
        bus_ev.in_valid = 1'b1;
        n = 0;
        while (bus_ev.in_ready !== 1'b1) begin
            if (n > 100) begin
                $display("FAIL %s.accept: in_ready stayed low for %0d cycles", name, n);
                $fatal(1, "command never accepted");
            end
            @(negedge clk);
            n++;
        end
        if (want) begin
            sb_ev.push_back('{flag: fe, value: ve, cyc: cyc + 3, occ: oe, name: name});
            sb_fu.push_back('{flag: ff, value: vf, cyc: cyc + 3, occ: of_, name: name});
        end
        @(posedge clk);
        #1;
        bus_ev.in_valid = 1'b0;
    endtask

    initial begin
        bus_ev.in_valid = 1'b0;
        bus_ev.in_flag  = '0;
        bus_ev.in_hash  = '0;
        bus_ev.in_key   = '0;
        bus_ev.in_value = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        //     name       op   hash          key val    want ev: flag val    occ  fu: flag val    occ
        issue("lkA0",     LK,  32'hDEAD_BE03, KA, 32'h0,  1, MISS, 32'h0,  0, MISS, 32'h0,  0);
        issue("insA",     INS, 32'hDEAD_BE03, KA, 32'h11, 1, INSD, 32'h0,  1, INSD, 32'h0,  1);
        issue("lkA1",     LK,  32'hDEAD_BE03, KA, 32'h0,  1, HIT,  32'h11, 1, HIT,  32'h11, 1);
        issue("updA",     INS, 32'h0000_0003, KA, 32'h22, 1, UPD,  32'h11, 1, UPD,  32'h11, 1);
        issue("lkA2",     LK,  32'hDEAD_BE03, KA, 32'h0,  1, HIT,  32'h22, 1, HIT,  32'h22, 1);
        issue("insP",     INS, 32'h0000_0005, KP, 32'hA1, 1, INSD, 32'h0,  2, INSD, 32'h0,  2);
        issue("insQ",     INS, 32'h1234_5675, KQ, 32'hA2, 1, INSD, 32'h0,  3, INSD, 32'h0,  3);
        issue("insR",     INS, 32'hFFFF_FFF5, KR, 32'hA3, 1, EVT,  32'hA1, 3, FULL, 32'h0,  3);
        issue("lkP",      LK,  32'h0000_0005, KP, 32'h0,  1, MISS, 32'h0,  3, HIT,  32'hA1, 3);
        issue("lkR",      LK,  32'h0000_0005, KR, 32'h0,  1, HIT,  32'hA3, 3, MISS, 32'h0,  3);
        issue("insS",     INS, 32'h0000_0005, KS, 32'hA4, 1, EVT,  32'hA2, 3, FULL, 32'h0,  3);
        issue("delA",     DEL, 32'hDEAD_BE03, KA, 32'h0,  1, DELD, 32'h22, 2, DELD, 32'h22, 2);
        issue("delA2",    DEL, 32'hDEAD_BE03, KA, 32'h0,  1, MISS, 32'h0,  2, MISS, 32'h0,  2);
        issue("illegal",  4'd9,32'hDEAD_BE03, KA, 32'h77, 1, ERR,  32'h0,  2, ERR,  32'h0,  2);
        issue("delP",     DEL, 32'h0000_0005, KP, 32'h0,  1, MISS, 32'h0,  2, DELD, 32'hA1, 1);
        issue("insS2",    INS, 32'h0000_0005, KS, 32'hA5, 1, UPD,  32'hA4, 2, INSD, 32'h0,  2);
        issue("insU",     INS, 32'h0000_0005, KU, 32'hA6, 1, EVT,  32'hA3, 2, FULL, 32'h0,  2);

        // Abort an INSERT with reset during cycle T+2.
        issue("abortT",   INS, 32'h0000_0007, KT, 32'h55, 0, ERR,  32'h0,  0, ERR,  32'h0,  0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        issue("lkT",      LK,  32'h0000_0007, KT, 32'h0,  1, MISS, 32'h0,  0, MISS, 32'h0,  0);
        issue("lkS",      LK,  32'h0000_0005, KS, 32'h0,  1, MISS, 32'h0,  0, MISS, 32'h0,  0);
        issue("insA3",    INS, 32'hDEAD_BE03, KA, 32'h33, 1, INSD, 32'h0,  1, INSD, 32'h0,  1);
        issue("lkA3",     LK,  32'hDEAD_BE03, KA, 32'h0,  1, HIT,  32'h33, 1, HIT,  32'h33, 1);

        repeat (12) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/db_hash_table.md
# db_hash_table

Parametrised N-way set-associative key/value table that succeeds the single-bucket database controller behind the packet-filter database top. It accepts one lookup, insert or delete command at a time, indexed by an externally computed hash such as the CRC32 output. It stores full keys and values in on-chip synchronous RAM and returns a status code, a value and a live occupancy count. It adds a power-up clear sweep, multi-way replacement and a selectable eviction mode.

## Interface
- KEY_SIZE, 96, key width in bits (5-tuple style tag)
- VAL_SIZE, 32, value width in bits
- HASH_SIZE, 32, width of in_hash
- IDX_BITS, 8, bucket index width; DEPTH = 2^IDX_BITS buckets
- WAYS, 2, ways per bucket, power of two, 1..8
- EVICT_EN, 1, 1 = evict on full bucket, 0 = report FULL
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  command valid
- in_ready  out  1  block can accept a command
- in_flag  in  4  opcode: 1 LOOKUP, 2 INSERT, 3 DELETE; any other value is illegal
- in_hash  in  HASH_SIZE  hash of in_key; the index is in_hash[IDX_BITS-1:0]
- in_key  in  KEY_SIZE  key
- in_value  in  VAL_SIZE  value; used by INSERT only
- out_valid  out  1  one-cycle result strobe
- out_flag  out  4  status: 1 HIT, 2 MISS, 3 INSERTED, 4 UPDATED, 5 EVICTED, 6 FULL, 7 DELETED, 15 ERR
- out_value  out  VAL_SIZE  stored value (HIT, DELETED) or displaced value (UPDATED, EVICTED); otherwise 0
- occupancy  out  IDX_BITS+log2(WAYS)+1  number of valid entries

## Operation
- Storage per way: a valid bit, the full key and the value, DEPTH entries each.
- FSM states: INIT, IDLE, RD, CMP, RESP.
- INIT:
  - Entered on reset.
  - A counter sweeps index 0..DEPTH-1 and clears the valid bits of all ways at each index, one index per cycle.
  - After index DEPTH-1 the FSM goes to IDLE.
- IDLE:
  - in_ready = 1.
  - A command is accepted when in_valid and in_ready are both high.
  - On accept, opcode, index, key and value are registered and the FSM goes to RD.
- RD: the bucket read is issued at the registered index; go to CMP.
- CMP:
  - Each way's match = valid and stored key equal to the registered key.
  - Registered results: hit way (lowest matching way), first free way (lowest invalid way), and bucket-full.
- RESP: executes the command, pulses out_valid, returns to IDLE.
  - LOOKUP: HIT with the stored value, or MISS.
  - INSERT:
    - Key hit: overwrite the value and return UPDATED with the old value.
    - Else a free way exists: write it and return INSERTED; occupancy +1.
    - Else EVICT_EN=1: overwrite way victim_ptr, return EVICTED with the old value, then victim_ptr +1 modulo WAYS; occupancy unchanged.
    - Else (EVICT_EN=0): return FULL and leave the table untouched.
  - DELETE: on hit, clear the valid bit, return DELETED with the value, occupancy -1; otherwise MISS.
  - Illegal opcode: ERR, no write, value 0.
- victim_ptr is one global log2(WAYS)-bit counter. It resets to 0 and advances only on eviction.
- Only one command is in flight at a time, so there are no read/write hazards.

## Timing
- Reset values:
  - in_ready = 0, out_valid = 0, out_flag = 0, out_value = 0, occupancy = 0.
  - victim_ptr = 0, FSM = INIT with the sweep counter at 0.
- Reset assertion mid-command aborts the command: no out_valid, the table is re-cleared, and any write not yet performed is lost.
- After reset release, in_ready rises on cycle DEPTH (cycles 0..DEPTH-1 are the sweep).
- With the accept edge at cycle T:
  - in_ready = 0 during T+1..T+3.
  - out_valid = 1 for exactly cycle T+3.
  - The RAM write commits at the end of T+3.
  - occupancy reflects the command from T+4.
  - in_ready = 1 again at T+4.
- Throughput: one command per 4 cycles.
- out_flag and out_value hold their last value until the next out_valid; out_valid is never held.
- in_valid while in_ready = 0 is ignored; the source holds its command until accepted.
- A LOOKUP accepted at T+4 sees the write made at T+3.
- occupancy never exceeds DEPTH*WAYS and never underflows.

## Test plan
Bench configuration for all scenarios: IDX_BITS=4, WAYS=2.

- Reset, then release -> in_ready low for 16 cycles and high on cycle 16; occupancy=0; a LOOKUP of any key returns MISS.
- INSERT key A (hash 0x3, value 0x11), then LOOKUP A -> INSERTED, then HIT with 0x11 exactly 3 cycles after each accept; occupancy=1.
- INSERT A with value 0x22 -> UPDATED, out_value=0x11; a following LOOKUP returns 0x22; occupancy stays 1.
- EVICT_EN=1, INSERT A, B, C all with hash 0x5 -> INSERTED, INSERTED, EVICTED (out_value = A's value); LOOKUP A -> MISS; occupancy=2. Rerun with EVICT_EN=0 -> C returns FULL and A remains.
- DELETE A -> DELETED, occupancy -1; DELETE A again -> MISS; in_flag=9 -> ERR with out_value=0.
- Reset asserted at cycle T+2 of an INSERT -> no out_valid, occupancy=0 after release, and a LOOKUP of that key returns MISS.
